memory_port_arbiter: RTL and testbench

// Shares the single main-memory port between the pipeline's instruction-fetch

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/mem_align_check.sv | 25 ++
 rtl/memory_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_memory_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared memory-size encodings and arbiter state type.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam logic [1:0] MEM_SZ_NONE = 2'b00;
    localparam logic [1:0] MEM_SZ_BYTE = 2'b01;
    localparam logic [1:0] MEM_SZ_HALF = 2'b10;
    localparam logic [1:0] MEM_SZ_WORD = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_I_BUSY = 2'd1,
        ARB_D_BUSY = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/mem_align_check.sv
`default_nettype none
// ============================================================================
// Module      : mem_align_check
// Description : Flags data accesses whose address is not aligned to their size.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_align_check
    import cpu_pkg::*;
(
    input  logic [1:0] addr_lo_i,
    input  logic [1:0] size_i,
    input  logic       read_i,
    output logic       misaligned_o
);

    logic [1:0] w_size;

    // Loads carry no size of their own and are always full-word accesses.
    assign w_size = (size_i == MEM_SZ_NONE && read_i) ? MEM_SZ_WORD : size_i;

    assign misaligned_o = ((w_size == MEM_SZ_HALF) && addr_lo_i[0]) ||
                          ((w_size == MEM_SZ_WORD) && (addr_lo_i != 2'b00));

endmodule
`default_nettype wire

// File: rtl/memory_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_port_arbiter
// Description : Shares one memory port between fetch and data requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_port_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_flush,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic              d_read,
    input  logic [1:0]        d_write,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              mem_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic [1:0]        mem_write,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int                    c_starve_w   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);

    arb_state_e            state_q, state_d;
    logic [c_starve_w-1:0] starve_q, starve_d;
    logic                  cancel_q, cancel_d;
    logic                  is_fetch_q, is_fetch_d;
    logic                  err_q, err_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  mem_valid_q, mem_valid_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic                  mem_read_q, mem_read_d;
    logic [1:0]            mem_write_q, mem_write_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

    logic w_misaligned;
    logic w_grant_fetch;

    mem_align_check u_align (
        .addr_lo_i    (d_addr[1:0]),
        .size_i       (d_write),
        .read_i       (d_read),
        .misaligned_o (w_misaligned)
    );

    // A flushed fetch is never granted; a starved fetch beats a waiting data request.
    assign w_grant_fetch = i_req && !i_flush && (!d_req || (starve_q == c_starve_max));

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        cancel_d    = cancel_q;
        is_fetch_d  = is_fetch_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (!i_req) begin
                    starve_d = '0;
                end
                if (w_grant_fetch) begin
                    state_d     = ARB_I_BUSY;
                    starve_d    = '0;
                    cancel_d    = 1'b0;
                    is_fetch_d  = 1'b1;
                    mem_valid_d = 1'b1;
                    mem_addr_d  = i_addr & ~ADDR_W'(3);
                    mem_read_d  = 1'b1;
                    mem_write_d = MEM_SZ_NONE;
                    mem_wdata_d = '0;
                end else if (d_req) begin
                    is_fetch_d = 1'b0;
                    if (i_req && (starve_q != c_starve_max)) begin
                        starve_d = starve_q + 1'b1;
                    end
                    if (w_misaligned) begin
                        err_d   = 1'b1;
                        state_d = ARB_RESP;
                    end else if (!d_read && (d_write == MEM_SZ_NONE)) begin
                        state_d = ARB_RESP;
                    end else begin
                        state_d     = ARB_D_BUSY;
                        mem_valid_d = 1'b1;
                        mem_addr_d  = d_addr;
                        mem_read_d  = d_read;
                        mem_write_d = d_write;
                        mem_wdata_d = d_wdata;
                    end
                end
            end
            ARB_I_BUSY, ARB_D_BUSY: begin
                if ((state_q == ARB_I_BUSY) && i_flush) begin
                    cancel_d = 1'b1;
                end
                if (mem_ready) begin
                    rdata_d     = mem_rdata;
                    mem_valid_d = 1'b0;
                    state_d     = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d  = ARB_IDLE;
                cancel_d = 1'b0;
                err_d    = 1'b0;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB_IDLE;
            starve_q    <= '0;
            cancel_q    <= 1'b0;
            is_fetch_q  <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= MEM_SZ_NONE;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            cancel_q    <= cancel_d;
            is_fetch_q  <= is_fetch_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // A flush arriving during the response cycle still cancels the fetch.
    assign i_ack     = (state_q == ARB_RESP) && is_fetch_q && !cancel_q && !i_flush;
    assign d_ack     = (state_q == ARB_RESP) && !is_fetch_q && !err_q;
    assign d_err     = (state_q == ARB_RESP) && !is_fetch_q && err_q;
    assign i_rdata   = rdata_q;
    assign d_rdata   = rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_port_arbiter
// Description : Scoreboard bench for memory_port_arbiter with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_port_arbiter;
    import cpu_pkg::*;

    typedef struct packed {
        logic        err;
        logic        chk_data;
        logic [31:0] data;
    } d_exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0, i_flush = 1'b0, i_ack;
    logic [31:0] i_addr = '0, i_rdata;
    logic        d_req = 1'b0, d_read = 1'b0, d_ack, d_err;
    logic [1:0]  d_write = 2'b00;
    logic [31:0] d_addr = '0, d_wdata = '0, d_rdata;
    logic        mem_valid, mem_read;
    logic [1:0]  mem_write;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_pass = 0, n_tot = 0;
    int i_ack_cnt = 0, mem_cmd_cnt = 0, mem_done_cnt = 0;
    bit stall = 1'b0, fast = 1'b1;

    logic [31:0] i_exp_q[$];
    d_exp_t      d_exp_q[$];
    bit          i_cmd_pend = 1'b0, d_cmd_pend = 1'b0;
    logic [31:0] i_cmd_addr = '0, d_cmd_addr = '0, d_cmd_wdata = '0;
    logic        d_cmd_read = 1'b0;
    logic [1:0]  d_cmd_write = 2'b00;

    logic        prev_valid = 1'b0;
    logic [66:0] prev_cmd = '0;

    always #5 clk = ~clk;

    memory_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Memory model: random or immediate ready, data is a fixed function of address.
    always @(posedge clk) begin
        #2;
        mem_ready = mem_valid && !stall && (fast || ($urandom_range(0, 2) != 0));
        mem_rdata = mem_fn(mem_addr);
    end

    always @(negedge clk) begin
        bit     i_m, d_m;
        d_exp_t e;
        if (!rst) begin
            i_m = i_cmd_pend && mem_addr == i_cmd_addr && mem_read && mem_write == MEM_SZ_NONE;
            d_m = d_cmd_pend && mem_addr == d_cmd_addr && mem_read == d_cmd_read &&
                  mem_write == d_cmd_write && (d_cmd_write == MEM_SZ_NONE || mem_wdata == d_cmd_wdata);
            if (mem_valid && !prev_valid) begin
                mem_cmd_cnt++;
                chk("mem_cmd_match", 64'(i_m || d_m), 64'd1);
            end else if (mem_valid) begin
                chk("mem_cmd_stable", 64'({mem_addr, mem_read, mem_write, mem_wdata} == prev_cmd), 64'd1);
            end
            if (mem_valid && mem_ready) mem_done_cnt++;
            if (i_ack && (d_ack || d_err)) chk("ack_exclusive", 64'd1, 64'd0);
            if (i_ack) begin
                i_ack_cnt++;
                if (i_exp_q.size() == 0) chk("unexpected_i_ack", 64'd1, 64'd0);
                else chk("i_rdata", 64'(i_rdata), 64'(i_exp_q.pop_front()));
            end
            if (d_ack || d_err) begin
                if (d_exp_q.size() == 0) chk("unexpected_d_resp", 64'd1, 64'd0);
                else begin
                    e = d_exp_q.pop_front();
                    chk("d_err_vs_ack", 64'({d_err, d_ack}), 64'({e.err, !e.err}));
                    if (e.chk_data && d_ack) chk("d_rdata", 64'(d_rdata), 64'(e.data));
                end
            end
        end
        prev_valid = mem_valid && !rst;
        prev_cmd   = {mem_addr, mem_read, mem_write, mem_wdata};
    end

    task automatic drive_fetch(input logic [31:0] a, input bit expect_ack);
        logic [31:0] wa;
        wa         = {a[31:2], 2'b00};
        i_cmd_pend = 1'b1;
        i_cmd_addr = wa;
        if (expect_ack) i_exp_q.push_back(mem_fn(wa));
        i_req  = 1'b1;
        i_addr = a;
    endtask

    task automatic drive_data(input logic [31:0] a, input logic rd, input logic [1:0] wr,
                              input logic [31:0] wd);
        d_exp_t      e;
        int unsigned nbytes;
        nbytes      = (wr != 2'b00) ? (1 << (wr - 1)) : (rd ? 4 : 1);
        e.err       = (a % nbytes) != 0;
        e.chk_data  = rd && !e.err;
        e.data      = mem_fn(a);
        d_exp_q.push_back(e);
        d_cmd_pend  = !e.err && (rd || wr != 2'b00);
        d_cmd_addr  = a;
        d_cmd_read  = rd;
        d_cmd_write = wr;
        d_cmd_wdata = wd;
        d_req = 1'b1; d_addr = a; d_read = rd; d_write = wr; d_wdata = wd;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drop_i();
        @(posedge clk); #1;
        i_req = 1'b0; i_cmd_pend = 1'b0;
    endtask

    task automatic drop_d();
        @(posedge clk); #1;
        d_req = 1'b0; d_read = 1'b0; d_write = 2'b00; d_cmd_pend = 1'b0;
    endtask

    task automatic wait_resp(output bit got_i, output bit got_d, output int cyc);
        got_i = 1'b0; got_d = 1'b0; cyc = 0;
        forever begin
            @(negedge clk);
            got_i = i_ack;
            got_d = d_ack || d_err;
            if (got_i || got_d) break;
            cyc++;
            if (cyc > 300) begin
                chk("resp_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic wait_own(input bit is_i);
        int cyc = 0;
        forever begin
            @(negedge clk);
            if (is_i ? i_ack : (d_ack || d_err)) break;
            cyc++;
            if (cyc > 500) begin
                chk(is_i ? "fetch_timeout" : "data_timeout", 64'd0, 64'd1);
                break;
            end
        end
    endtask

    task automatic rand_fetches(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            drive_fetch({20'd0, 12'($urandom)}, 1'b1);
            wait_own(1'b1);
            drop_i();
            idle($urandom_range(0, 3));
        end
    endtask

    task automatic rand_data(input int n);
        int unsigned r;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            r = $urandom_range(0, 9);
            if (r < 4)       drive_data({20'd0, 10'($urandom), 2'b00}, 1'b1, 2'b00, '0);
            else if (r == 4) drive_data({20'd0, 12'($urandom)}, 1'b1, 2'b00, '0);
            else if (r < 9)  drive_data({20'd0, 12'($urandom)}, 1'b0, 2'($urandom_range(1, 3)), $urandom);
            else             drive_data({20'd0, 12'($urandom)}, 1'b0, 2'b00, '0);
            wait_own(1'b0);
            drop_d();
            idle($urandom_range(0, 2));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit gi, gd, got_fetch;
        int cyc, nd, b_i, b_done, b_cmd;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", 64'({i_ack, d_ack, d_err, mem_valid, mem_read, mem_write}), 64'd0);
        chk("reset_data", 64'(i_rdata | d_rdata | mem_addr | mem_wdata), 64'd0);
        rst = 1'b0;
        idle(2);

        // Fetch alone with an always-ready memory.
        drive_fetch(32'h100, 1'b1);
        wait_resp(gi, gd, cyc);
        chk("t1_ack_port", 64'({gi, gd}), 64'b10);
        chk("t1_ack_cycle", 64'(cyc), 64'd2);
        chk("t1_rdata", 64'(i_rdata), 64'h0050_0093);
        drop_i();
        idle(2);

        // Simultaneous fetch and word store: data wins.
        drive_fetch(32'h180, 1'b1);
        drive_data(32'h200, 1'b0, MEM_SZ_WORD, 32'hDEAD_BEEF);
        wait_resp(gi, gd, cyc);
        chk("t2_data_first", 64'({gi, gd}), 64'b01);
        drop_d();
        wait_resp(gi, gd, cyc);
        chk("t2_fetch_second", 64'({gi, gd}), 64'b10);
        drop_i();
        idle(2);

        // Fetch held against back-to-back loads: anti-starvation guard.
        drive_fetch(32'h300, 1'b1);
        drive_data(32'h400, 1'b1, MEM_SZ_NONE, '0);
        nd = 0; got_fetch = 1'b0;
        for (int k = 0; k < 8 && !got_fetch; k++) begin
            wait_resp(gi, gd, cyc);
            if (gi) got_fetch = 1'b1;
            else if (gd) begin
                nd++;
                @(posedge clk); #1;
                drive_data(32'h400 + 32'(4 * nd), 1'b1, MEM_SZ_NONE, '0);
            end else break;
        end
        chk("t3_data_acks_before_fetch", 64'(nd), 64'd4);
        chk("t3_fetch_granted", 64'(got_fetch), 64'd1);
        drop_i();
        wait_resp(gi, gd, cyc);
        chk("t3_pending_data_done", 64'({gi, gd}), 64'b01);
        drop_d();
        idle(2);

        // Flush during a stalled fetch: memory completes, no i_ack.
        b_i = i_ack_cnt; b_done = mem_done_cnt;
        stall = 1'b1;
        drive_fetch(32'h80, 1'b0);
        idle(1);
        i_flush = 1'b1; i_req = 1'b0;
        idle(1);
        i_flush = 1'b0;
        idle(3);
        stall = 1'b0;
        idle(4);
        i_cmd_pend = 1'b0;
        chk("t4_mem_completed", 64'(mem_done_cnt - b_done), 64'd1);
        chk("t4_no_i_ack", 64'(i_ack_cnt - b_i), 64'd0);
        drive_fetch(32'h40, 1'b1);
        wait_resp(gi, gd, cyc);
        chk("t4_next_fetch", 64'({gi, gd}), 64'b10);
        drop_i();
        idle(2);

        // Misaligned accesses are rejected without a memory cycle.
        b_cmd = mem_cmd_cnt;
        drive_data(32'h203, 1'b0, MEM_SZ_HALF, 32'h1234);
        wait_resp(gi, gd, cyc);
        chk("t5_half_err", 64'({d_err, d_ack}), 64'b10);
        drop_d();
        idle(1);
        drive_data(32'h202, 1'b1, MEM_SZ_NONE, '0);
        wait_resp(gi, gd, cyc);
        chk("t5_load_err", 64'({d_err, d_ack}), 64'b10);
        drop_d();
        idle(2);
        chk("t5_no_mem_cycle", 64'(mem_cmd_cnt - b_cmd), 64'd0);

        // Asynchronous reset in the middle of a data transaction.
        stall = 1'b1;
        drive_data(32'h300, 1'b0, MEM_SZ_WORD, 32'hCAFE_F00D);
        idle(2);
        chk("t6_valid_before_rst", 64'(mem_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_ctrl_in_rst", 64'({i_ack, d_ack, d_err, mem_valid, mem_read, mem_write}), 64'd0);
        chk("t6_data_in_rst", 64'(mem_addr | mem_wdata | d_rdata), 64'd0);
        d_req = 1'b0; d_write = 2'b00; d_cmd_pend = 1'b0; stall = 1'b0;
        d_exp_q.delete();
        i_exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        drive_data(32'h304, 1'b1, MEM_SZ_NONE, '0);
        wait_resp(gi, gd, cyc);
        chk("t6_fresh_load", 64'({d_ack, d_err}), 64'b10);
        drop_d();
        idle(2);

        // Randomized concurrent traffic with a slow memory.
        fast = 1'b0;
        fork
            rand_fetches(40);
            rand_data(60);
        join
        idle(5);
        chk("queues_drained", 64'(i_exp_q.size() + d_exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
